lsu_ctrl: RTL and testbench

//  Load/store initiator for the byte-addressed data memory port (en/wr/strb/addr/wdata/rdata).

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 34 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Size codes follow RV64 funct3[1:0]; funct3[2] selects zero-extension on loads.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int         F3_UNS        = 2;
  localparam logic [2:0] F3_ILLEGAL_LD = 3'b111;

  function automatic logic [7:0] size_to_strb(input logic [1:0] size);
    logic [7:0] strb;
    case (size)
      SZ_B:    strb = 8'h01;
      SZ_H:    strb = 8'h03;
      SZ_W:    strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus data-memory port of the load/store unit.
// slave = LSU view, master = core/memory environment view.
interface lsu_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_wr;
  logic [7:0]        mem_strb;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_wr, mem_strb, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_wr, mem_strb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational helpers: request legality (optionally trapping misalignment under
// LSU_MISALIGN_TRAP_EN), byte strobe generation and load data extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_chk_wr,
  input  logic [2:0]  i_chk_funct3,
`ifdef LSU_MISALIGN_TRAP_EN
  input  logic [2:0]  i_chk_addr_lo,
`endif
  output logic        o_illegal,
  input  logic [2:0]  i_funct3,
  output logic [7:0]  o_strb,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_ext_data
);

  logic w_bad_code;
  logic w_uns;

  assign w_bad_code = i_chk_wr ? i_chk_funct3[F3_UNS] : (i_chk_funct3 == F3_ILLEGAL_LD);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (i_chk_funct3[1:0])
      SZ_H:    w_misalign = i_chk_addr_lo[0];
      SZ_W:    w_misalign = |i_chk_addr_lo[1:0];
      SZ_D:    w_misalign = |i_chk_addr_lo;
      default: w_misalign = 1'b0;
    endcase
  end

  assign o_illegal = w_bad_code | w_misalign;
`else
  assign o_illegal = w_bad_code;
`endif

  assign o_strb = size_to_strb(i_funct3[1:0]);
  assign w_uns  = i_funct3[F3_UNS];

  // Memory returns data already lane-masked, so only the top byte lane needs extending.
  always_comb begin
    o_ext_data = i_rdata;
    case (i_funct3[1:0])
      SZ_B:    o_ext_data = {{56{~w_uns & i_rdata[7]}},  i_rdata[7:0]};
      SZ_H:    o_ext_data = {{48{~w_uns & i_rdata[15]}}, i_rdata[15:0]};
      SZ_W:    o_ext_data = {{32{~w_uns & i_rdata[31]}}, i_rdata[31:0]};
      default: o_ext_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, load wait states via down-counter.
// Misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | req_ready=1, waiting for req_valid; illegal requests skip to RESP
// ST_ACCESS | memory port driven; store 1 cycle, load WAIT_CYCLES cycles
// ST_RESP   | resp_valid=1 with stable data/err until resp_ready
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 64
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_wr;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_illegal;
  logic              w_accept;
  logic              w_cnt_tc;
  logic [7:0]        w_strb;
  logic [63:0]       w_ext;

  lsu_align u_align (
    .i_chk_wr      (bus.req_wr),
    .i_chk_funct3  (bus.req_funct3),
`ifdef LSU_MISALIGN_TRAP_EN
    .i_chk_addr_lo (bus.req_addr[2:0]),
`endif
    .o_illegal     (w_illegal),
    .i_funct3      (r_funct3),
    .o_strb        (w_strb),
    .i_rdata       (bus.mem_rdata),
    .o_ext_data    (w_ext)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_cnt_tc = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = w_illegal ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_wr || w_cnt_tc) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory port is purely decoded from state so an async reset releases it at once.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_strb   = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (r_state)
      ST_IDLE: bus.req_ready = 1'b1;
      ST_ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = r_wr;
        bus.mem_strb  = w_strb;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = r_rdata;
        bus.resp_err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_wr     <= bus.req_wr;
      r_funct3 <= bus.req_funct3;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_rdata  <= '0;
      r_err    <= w_illegal;
      r_cnt    <= CNT_LOAD;
    end else if ((r_state == ST_ACCESS) && !r_wr) begin
      if (w_cnt_tc) begin
        r_rdata <= w_ext;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-array memory reference model.
// Honours LSU_MISALIGN_TRAP_EN when deciding which accesses are expected to trap.
module tb_lsu_ctrl;

  localparam int WAIT   = 3;
  localparam int ADDR_W = 64;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_loaded = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  lsu_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Byte-granular memory; read data masked by strobes.
  always_comb begin
    bus.mem_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_en && bus.mem_strb[k]) begin
        bus.mem_rdata[8*k +: 8] = mem[8'(bus.mem_addr[7:0] + 8'(k))];
      end
    end
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_en && bus.mem_wr) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.mem_strb[k]) mem[8'(bus.mem_addr[7:0] + 8'(k))] <= bus.mem_wdata[8*k +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_illegal(input bit wr, input logic [2:0] f3, input logic [63:0] addr);
    int nb;
    bit bad;
    nb  = 1 << f3[1:0];
    bad = wr ? f3[2] : (f3 == 3'b111);
    if (TRAP && ((addr % 64'(nb)) != 0)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
    int nb;
    logic [63:0] val;
    nb  = 1 << f3[1:0];
    val = '0;
    for (int i = 0; i < nb; i++) val = val | (64'(ref_mem[8'(addr[7:0] + 8'(i))]) << (8*i));
    if (!f3[2] && nb < 8 && val[8*nb-1]) val = val | ~((64'd1 << (8*nb)) - 64'd1);
    return val;
  endfunction

  task automatic reset_outputs_check(input string tag);
    check({tag, "_mem_en"},     64'(bus.mem_en), 64'd0);
    check({tag, "_mem_wr"},     64'(bus.mem_wr), 64'd0);
    check({tag, "_mem_strb"},   64'(bus.mem_strb), 64'd0);
    check({tag, "_mem_addr"},   bus.mem_addr, 64'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata, 64'd0);
    check({tag, "_req_ready"},  64'(bus.req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_err"},   64'(bus.resp_err), 64'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
  endtask

  task automatic do_op(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input int hold, input string tag,
                       output logic [63:0] rdata_o, output logic err_o);
    bit          ill;
    int          nb, exp_en, lat, en_cnt;
    logic [7:0]  s_strb, exp_strb;
    logic [63:0] s_addr, s_wdata, exp_rd;
    logic        s_wr;
    bit          rdy_bad, stab_bad;

    ill      = model_illegal(wr, f3, addr);
    nb       = 1 << f3[1:0];
    exp_en   = ill ? 0 : (wr ? 1 : WAIT);
    exp_strb = (nb == 8) ? 8'hFF : 8'((1 << nb) - 1);
    exp_rd   = (ill || wr) ? 64'd0 : model_load(f3, addr);
    s_strb = 'x; s_addr = 'x; s_wdata = 'x; s_wr = 'x;

    @(negedge clk);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_wr     = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};

    @(negedge clk);
    lat = 1; en_cnt = 0; rdy_bad = 1'b0;
    while (!bus.resp_valid && lat < 40) begin
      if (bus.mem_en) begin
        if (en_cnt == 0) begin
          s_strb = bus.mem_strb; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_wr = bus.mem_wr;
        end
        en_cnt++;
      end
      if (bus.req_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end

    check({tag, "_latency"}, 64'(lat), 64'(ill ? 1 : exp_en + 1));
    check({tag, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
    check({tag, "_ready_busy"}, 64'(rdy_bad), 64'd0);
    if (exp_en > 0) begin
      check({tag, "_strb"}, 64'(s_strb), 64'(exp_strb));
      check({tag, "_addr"}, s_addr, addr);
      check({tag, "_wr"}, 64'(s_wr), 64'(wr));
      if (wr) check({tag, "_wdata"}, s_wdata, wdata);
    end

    rdata_o = bus.resp_rdata;
    err_o   = bus.resp_err;
    check({tag, "_err"}, 64'(err_o), 64'(ill));
    check({tag, "_rdata"}, rdata_o, exp_rd);

    stab_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_rdata !== rdata_o || bus.resp_err !== err_o ||
          bus.req_ready || bus.mem_en) stab_bad = 1'b1;
    end
    if (hold > 0) check({tag, "_resp_stable"}, 64'(stab_bad), 64'd0);

    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;

    if (wr && !ill) begin
      for (int i = 0; i < nb; i++) ref_mem[8'(addr[7:0] + 8'(i))] = wdata[8*i +: 8];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          mism;

    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    mem_loaded = 1'b1;
    @(negedge clk);
    reset_outputs_check("reset");
    rst_n = 1'b1;

    do_op(1'b1, 3'b011, 64'h100, 64'h1122334455667788, 0, "sd", rd, er);
    do_op(1'b0, 3'b011, 64'h100, 64'h0, 0, "ld", rd, er);
    check("ld_const", rd, 64'h1122334455667788);
    do_op(1'b0, 3'b000, 64'h100, 64'h0, 1, "lb", rd, er);
    check("lb_const", rd, 64'hFFFFFFFFFFFFFF88);
    do_op(1'b0, 3'b100, 64'h100, 64'h0, 0, "lbu", rd, er);
    check("lbu_const", rd, 64'h88);
    do_op(1'b0, 3'b010, 64'h102, 64'h0, 0, "lw_mis", rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_trap", 64'(er), 64'd1);
`else
    check("lw_mis_ok", 64'(er), 64'd0);
`endif
    do_op(1'b0, 3'b011, 64'h100, 64'h0, 5, "ld_hold", rd, er);
    do_op(1'b0, 3'b111, 64'h110, 64'h0, 2, "ill_ld", rd, er);
    check("ill_ld_err_const", 64'(er), 64'd1);
    do_op(1'b1, 3'b100, 64'h118, 64'hDEADBEEFCAFEF00D, 0, "ill_st", rd, er);
    check("ill_st_err_const", 64'(er), 64'd1);

    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom), 3'($urandom), 64'h100 + 64'($urandom_range(0, 63)),
            {$urandom, $urandom}, $urandom_range(0, 3), "rnd", rd, er);
    end

    // Reset in the middle of a store access.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wr     = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h108;
    bus.req_wdata  = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_en", 64'(bus.mem_en), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_outputs_check("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image", 64'(mism), 64'd0);

    do_op(1'b0, 3'b011, 64'h108, 64'h0, 0, "ld_after_rst", rd, er);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
